// File: rtl/skein_pkg.sv
// Shared definitions for the Skein best-score sharing logic: default widths,
// the reset threshold and the arbiter FSM state encoding.
package skein_pkg;

    localparam int SCORE_W_DEFAULT = 10;

    // All ones and wide enough for any supported SCORE_W; users slice it to width.
    localparam logic [31:0] RESET_SCORE = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPARE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping,
// reported both one-hot and as a binary index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            // ptr_i is always below N, so a single subtraction wraps correctly
            cand = int'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/best_score_arbiter.sv
// Time-shares one best-score comparator among NUM_CORES hash cores: round-robin
// capture, one-cycle ack, then strict-improvement update of the held best.
module best_score_arbiter
    import skein_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int SCORE_W   = SCORE_W_DEFAULT,
    parameter int NONCE_W   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CORES-1:0]         req_i,
    input  logic [NUM_CORES*SCORE_W-1:0] score_i,
    input  logic [NUM_CORES*NONCE_W-1:0] nonce_i,
    output logic [NUM_CORES-1:0]         ack_o,
    input  logic                         load_i,
    input  logic [SCORE_W-1:0]           load_value_i,
    output logic [SCORE_W-1:0]           best_score_o,
    output logic [NONCE_W-1:0]           best_nonce_o,
    output logic                         best_valid_o,
    output logic                         new_best_o,
    output logic                         busy_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [SCORE_W-1:0] RST_SCORE = RESET_SCORE[SCORE_W-1:0];

    state_e                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       idx_q;
    logic [SCORE_W-1:0]     cap_score_q;
    logic [NONCE_W-1:0]     cap_nonce_q;
    logic [SCORE_W-1:0]     best_score_q;
    logic [NONCE_W-1:0]     best_nonce_q;
    logic                   best_valid_q;
    logic                   new_best_q;
    logic [NUM_CORES-1:0]   ack_q;

    logic [NUM_CORES-1:0]   grant;
    logic [IDX_W-1:0]       grant_idx;

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .en_i    (state_q == ST_IDLE),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            cap_score_q  <= '0;
            cap_nonce_q  <= '0;
            best_score_q <= RST_SCORE;
            best_nonce_q <= '0;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
            ack_q        <= '0;
        end else begin
            ack_q      <= '0;
            new_best_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        idx_q       <= grant_idx;
                        cap_score_q <= score_i[grant_idx*SCORE_W +: SCORE_W];
                        cap_nonce_q <= nonce_i[grant_idx*NONCE_W +: NONCE_W];
                        ack_q       <= grant;
                        state_q     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    ptr_q   <= (idx_q == IDX_W'(NUM_CORES - 1)) ? '0 : idx_q + 1'b1;
                    state_q <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    // Strict less-than: on a tie the earlier finder keeps the best.
                    if (!load_i && (cap_score_q < best_score_q)) begin
                        best_score_q <= cap_score_q;
                        best_nonce_q <= cap_nonce_q;
                        best_valid_q <= 1'b1;
                        new_best_q   <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // A host load overrides any compare result on the same edge.
            if (load_i) begin
                best_score_q <= load_value_i;
                best_nonce_q <= '0;
                best_valid_q <= 1'b0;
            end
        end
    end

    assign ack_o        = ack_q;
    assign best_score_o = best_score_q;
    assign best_nonce_o = best_nonce_q;
    assign best_valid_o = best_valid_q;
    assign new_best_o   = new_best_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_best_score_arbiter.sv
// Randomised bench for best_score_arbiter: a transaction-level predictor tracks
// the held best and expected grants; improvement pulses are checked from a queue.
module tb_best_score_arbiter;

    localparam int NC = 4;
    localparam int SW = 10;
    localparam int NW = 64;

    logic             clk;
    logic             rst_n;
    logic [NC-1:0]    req;
    logic [NC*SW-1:0] score_bus;
    logic [NC*NW-1:0] nonce_bus;
    logic [NC-1:0]    ack_o;
    logic             load_i;
    logic [SW-1:0]    load_value;
    logic [SW-1:0]    best_score_o;
    logic [NW-1:0]    best_nonce_o;
    logic             best_valid_o;
    logic             new_best_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;
    int refill_mode = 0;  // 0: drop after ack, 1: re-offer 500-k, 2: random

    logic [SW+NW-1:0] exp_q[$];

    best_score_arbiter #(.NUM_CORES(NC), .SCORE_W(SW), .NONCE_W(NW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .score_i      (score_bus),
        .nonce_i      (nonce_bus),
        .ack_o        (ack_o),
        .load_i       (load_i),
        .load_value_i (load_value),
        .best_score_o (best_score_o),
        .best_nonce_o (best_nonce_o),
        .best_valid_o (best_valid_o),
        .new_best_o   (new_best_o),
        .busy_o       (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic offer(input int k, input logic [SW-1:0] s, input logic [NW-1:0] n);
        score_bus[k*SW +: SW] = s;
        nonce_bus[k*NW +: NW] = n;
        req[k] = 1'b1;
    endtask

    function automatic logic [SW-1:0] rand_score();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return SW'($urandom_range(0, 1023));
    endfunction

    // Advance one cycle; cores react to an ack they see right after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        load_i = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (ack_o[k]) begin
                req[k] = 1'b0;
                if (refill_mode == 1)
                    offer(k, SW'(500 - k), NW'($urandom));
                else if (refill_mode == 2 && $urandom_range(0, 1) == 1)
                    offer(k, rand_score(), {$urandom, $urandom});
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- predictor ----------------
    // Inputs seen at a falling edge are what the next rising edge samples;
    // outputs seen there reflect the rising edge just passed.
    logic [SW-1:0] m_best;
    logic [NW-1:0] m_nonce;
    logic          m_valid;
    int            m_ptr, cyc, last_grant;
    bit            cmp_pend;
    int            cmp_due;
    logic [SW-1:0] cmp_s;
    logic [NW-1:0] cmp_n;
    logic [NC-1:0] p_req;
    logic [SW-1:0] p_sc [NC];
    logic [NW-1:0] p_nc [NC];
    logic          p_load;
    logic [SW-1:0] p_lval;

    initial begin
        logic [NC-1:0] exp_ack;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_best = '1; m_nonce = '0; m_valid = 1'b0;
                m_ptr = 0; cyc = 0; last_grant = -100; cmp_pend = 0;
                exp_q.delete();
            end else begin
                cyc++;
                if (p_load) begin
                    m_best = p_lval; m_nonce = '0; m_valid = 1'b0;
                end else if (cmp_pend && cmp_due == cyc && cmp_s < m_best) begin
                    m_best = cmp_s; m_nonce = cmp_n; m_valid = 1'b1;
                    exp_q.push_back({cmp_s, cmp_n});
                end
                if (cmp_pend && cmp_due == cyc) cmp_pend = 0;

                exp_ack = '0;
                if (cyc - last_grant >= 3 && p_req != '0) begin
                    for (int i = 0; i < NC; i++) begin
                        int c;
                        c = (m_ptr + i) % NC;
                        if (p_req[c]) begin
                            exp_ack[c] = 1'b1;
                            cmp_s = p_sc[c];
                            cmp_n = p_nc[c];
                            m_ptr = (c + 1) % NC;
                            break;
                        end
                    end
                    last_grant = cyc;
                    cmp_pend = 1;
                    cmp_due = cyc + 2;
                end
                chk("ack", 64'(ack_o), 64'(exp_ack));
                chk("busy", 64'(busy_o), 64'(cyc - last_grant <= 1));
                chk("best_score", 64'(best_score_o), 64'(m_best));
                chk("best_nonce", best_nonce_o, m_nonce);
                chk("best_valid", 64'(best_valid_o), 64'(m_valid));
            end
            p_req  = req;
            p_load = load_i;
            p_lval = load_value;
            for (int k = 0; k < NC; k++) begin
                p_sc[k] = score_bus[k*SW +: SW];
                p_nc[k] = nonce_bus[k*NW +: NW];
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [SW+NW-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (new_best_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_new_best", 64'(new_best_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("new_best_score", 64'(best_score_o), 64'(e[NW +: SW]));
                        chk("new_best_nonce", best_nonce_o, e[NW-1:0]);
                    end
                end else if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("missing_new_best", 64'(new_best_o), 64'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req = '0; score_bus = '0; nonce_bus = '0;
        load_i = 1'b0; load_value = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("reset_best_score", 64'(best_score_o), 64'd1023);
        chk("reset_best_valid", 64'(best_valid_o), 64'd0);
        chk("reset_ack", 64'(ack_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        steps(2);

        // Round robin: all cores held, core k scores 500-k.
        refill_mode = 1;
        for (int k = 0; k < NC; k++) offer(k, SW'(500 - k), NW'(32'h100 + k));
        steps(13);
        req = '0;
        refill_mode = 0;
        steps(5);
        chk("rr_best_score", 64'(best_score_o), 64'd497);

        // Single core offer.
        offer(2, 10'd400, 64'hDEAD);
        steps(3);
        chk("single_best_score", 64'(best_score_o), 64'd400);
        chk("single_best_nonce", best_nonce_o, 64'hDEAD);
        steps(3);

        // Tie and worse offers leave the best untouched.
        offer(3, 10'd300, 64'h3333);
        steps(5);
        offer(1, 10'd300, 64'h1111);
        offer(0, 10'd350, 64'h0);
        steps(10);
        chk("tie_best_score", 64'(best_score_o), 64'd300);
        chk("tie_best_nonce", best_nonce_o, 64'h3333);

        // Load lands on the COMPARE edge of a winning offer.
        offer(0, 10'd150, 64'h150);
        steps(2);
        load_i = 1'b1;
        load_value = 10'd200;
        steps(3);
        chk("load_best_score", 64'(best_score_o), 64'd200);
        chk("load_best_valid", 64'(best_valid_o), 64'd0);

        // Asynchronous reset while in COMPARE.
        offer(1, 10'd100, 64'hBEEF);
        steps(2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_best_score", 64'(best_score_o), 64'd1023);
        chk("arst_best_nonce", best_nonce_o, 64'd0);
        chk("arst_ack", 64'(ack_o), 64'd0);
        chk("arst_new_best", 64'(new_best_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        req = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        steps(6);

        // Randomised traffic with occasional loads and withdrawn offers.
        refill_mode = 2;
        for (int t = 0; t < 400; t++) begin
            step();
            for (int k = 0; k < NC; k++) begin
                if (!req[k] && $urandom_range(0, 3) == 0)
                    offer(k, rand_score(), {$urandom, $urandom});
                else if (req[k] && !ack_o[k] && $urandom_range(0, 39) == 0)
                    req[k] = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) begin
                load_i = 1'b1;
                load_value = rand_score();
            end
        end
        req = '0;
        refill_mode = 0;
        steps(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/best_score_arbiter.md
# best_score_arbiter

Shares the single best-score comparator among NUM_CORES Skein hash cores. Each core offers a Hamming-distance score and its nonce; the block selects offers round-robin, compares each against the held best score, and updates the comparator register contents and best nonce on strict improvement. The host seeds or resets the threshold through a load port. Downstream, the block drives the result/report logic and the host status readout.

## Interface
- NUM_CORES, 4, number of requesting hash cores (2..16)
- SCORE_W, 10, score width in bits (Hamming distance 0..1023)
- NONCE_W, 64, nonce width in bits

- clk_i  in  1  system clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  NUM_CORES  per-core result offer; held with data until matching ack_o
- score_i  in  NUM_CORES*SCORE_W  per-core score; core k at [k*SCORE_W +: SCORE_W]
- nonce_i  in  NUM_CORES*NONCE_W  per-core nonce; core k at [k*NONCE_W +: NONCE_W]
- ack_o  out  NUM_CORES  one-hot, one-cycle acceptance pulse
- load_i  in  1  host threshold write strobe
- load_value_i  in  SCORE_W  threshold written on load_i
- best_score_o  out  SCORE_W  current best / threshold
- best_nonce_o  out  NONCE_W  nonce that produced best_score_o
- best_valid_o  out  1  best_nonce_o is from a core, not a load
- new_best_o  out  1  one-cycle pulse on each improvement
- busy_o  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, CAPTURE, COMPARE.
- IDLE: if any req_i bit is high, grant by round-robin starting at ptr. Latch the granted index, score and nonce into capture registers. Go to CAPTURE.
- CAPTURE: assert ack_o[granted]. Set ptr = granted+1, wrapping from NUM_CORES-1 to 0. Go to COMPARE.
- COMPARE: if captured score < best_score_o (unsigned, strict), update best_score, best_nonce and best_valid=1, and pulse new_best_o. Ties and worse scores are dropped, so the first finder keeps the best. Always return to IDLE.
- load_i in any state: best_score <= load_value_i, best_nonce <= 0, best_valid <= 0.
- load_i in COMPARE: load wins, the compare result is discarded, and new_best_o stays low. The FSM still returns to IDLE, and ack already given is not revoked.
- A req_i deasserted before ack is ignored. No ack is owed for it.

## Timing
- Reset values: best_score_o all ones (1023), best_nonce_o 0, best_valid_o 0, new_best_o 0, ack_o 0, busy_o 0, ptr 0, state IDLE.
- Request at IDLE edge N: ack_o high during cycle N+1 (CAPTURE).
- Improvement: best_score_o/best_nonce_o and new_best_o are visible from cycle N+2 (COMPARE edge) for one cycle. Outputs are registered.
- Throughput: one offer per 3 cycles. Fairness: no core waits more than NUM_CORES grants.
- Each core must drop req_i, or present new data, the cycle after seeing ack_o. Because of the CAPTURE and COMPARE gap, the same offer is never granted twice.
- Score 0 is accepted and can never be beaten. Score 1023 never beats the reset threshold.

## Structure
- Shared package skein_pkg holds:
  - SCORE_W default
  - RESET_SCORE = {SCORE_W{1'b1}}
  - FSM state enum
- Sub-module rr_arbiter(N) takes req, ptr and en, and produces a one-hot grant plus the binary index. It is purely combinational.

## Test plan
- Reset: after rst_ni release, best_score_o=1023, best_valid_o=0, ack_o=0, busy_o=0.
- Single core: core 2 offers score 400 with nonce 0xDEAD. ack_o=4'b0100 one cycle later, then best_score_o=400, best_nonce_o=0xDEAD and new_best_o pulse one cycle after that.
- Round robin: all four req_i held, core k's score = 500−k. Acks come in order 0,1,2,3,0 and best_score_o is 497 after core 3.
- Tie/worse: best=300, then core 1 offers 300 and core 0 offers 350. Both are acked, best_nonce_o is unchanged and no new_best_o pulse occurs.
- Load collision: load_i=1 with load_value_i=200 in the COMPARE cycle of a score-150 offer. Result: best_score_o=200, best_valid_o=0, no new_best_o.
- Async reset mid-COMPARE: drive rst_ni low between edges. All outputs return to reset values immediately, and there is no ack or new_best_o afterwards.
